sysctl_icap_seq: RTL and testbench
==================================

Name: sysctl_icap_seq

Overview:
- CSR-mapped configuration-port sequencer; successor to the single-register ICAP write path in sysctl.
- Software pushes {ce_n, write_n, data} words into a FIFO. The block replays them autonomously onto a Xilinx ICAP-style port, generating its own port clock at a programmable divider.
- Software no longer has to pace writes. Status and a drain-complete interrupt are provided.
- Sits on the CSR bus beside sysctl.

Parameters:
- csr_addr, 4'h0: CSR bank select, compared with csr_a[13:10].
- data_width, 16: ICAP data width. Legal values are 8 and 16.
- fifo_depth_log2, 5: FIFO depth is 2**fifo_depth_log2 entries. Legal range 2..7.
- default_div, 8'd4: reset value of the clock divider.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset. Asynchronous, active-high.
- csr_a  in  14  CSR address.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered.
- icap_clk  out  1  generated port clock.
- icap_ce_n  out  1  port chip enable, active-low.
- icap_write_n  out  1  port write enable, active-low.
- icap_d  out  data_width  port data.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all outputs clear asynchronously, then follow the synchronous logic from the first sys_clk edge after release.
  - Output reset values: csr_do=0, icap_clk=0, icap_ce_n=1, icap_write_n=1, icap_d=0, irq=0.
  - Internal reset values: FIFO empty, overflow=0, div=default_div, irq_en=0, FSM=IDLE.
  - A reset asserted mid-sequence aborts the current entry and discards the FIFO contents.
- CSR select: a CSR access is addressed to this block when csr_a[13:10]==csr_addr. Register index is csr_a[1:0].
- csr_do: updated every cycle. It holds the selected register value one cycle after the address, and 0 when this block is not selected.
- Reg 0, DATA (write-only, reads 0):
  - A write pushes the entry {csr_di[17] write_n, csr_di[16] ce_n, csr_di[data_width-1:0]}.
  - Push when FIFO full: the entry is dropped and overflow is set.
- Reg 1, STATUS:
  - Read fields: [0]=busy (FSM not IDLE or FIFO non-empty), [1]=overflow (sticky), [2]=empty, [15:8]=FIFO level.
  - A write with bit1=1 clears overflow. If an overflowing push and the clear arrive in the same cycle, clear wins.
- Reg 2, CTRL (read/write):
  - [7:0]=div. A div value of 0 is treated as 1.
  - [8]=irq_en.
  - A div change takes effect at the next entry start, never mid-entry.
- Reg 3: reserved. Reads 0, writes are ignored.
- FSM states: IDLE, SETUP, HOLD.
- IDLE:
  - icap_clk=0, icap_ce_n=1, icap_write_n=1. icap_d holds its last value.
  - If the FIFO is non-empty: pop the head and latch it onto icap_d/icap_ce_n/icap_write_n, load the phase counter with div, go to SETUP.
- SETUP:
  - icap_clk=0; the latched entry is stable.
  - After div cycles, go to HOLD.
- HOLD:
  - icap_clk=1 for div cycles.
  - At the end: if the FIFO is non-empty, pop the next entry and go to SETUP without an IDLE cycle. Otherwise go to IDLE.
- Timing:
  - Each entry occupies exactly 2*div sys_clk cycles.
  - A DATA write accepted at edge N makes the FIFO non-empty after edge N.
  - The pop occurs at edge N+1 if the FSM is IDLE, and the port outputs change after edge N+1.
- Simultaneous push and pop: allowed in the same cycle. The level is unchanged and full/empty flags stay exact. A push into a full FIFO in the same cycle as a pop is accepted, since a slot frees that cycle.
- FIFO: circular buffer. Read/write pointers have fifo_depth_log2+1 bits (wrap bit). Full when pointers differ only in the MSB.
- irq: irq = irq_en & drained.
  - drained is set on the HOLD→IDLE transition.
  - drained clears on any DATA write or on a STATUS read.
- icap_clk, icap_ce_n, icap_write_n and icap_d are all driven from registers (glitch-free).

Test Plan:
- Reset check: assert sys_rst mid-way through the HOLD phase -> icap_ce_n=1, icap_write_n=1 and icap_clk=0 immediately, without waiting for a clock. STATUS then reads 0x00000004.
- Single entry, div=1: write DATA=0x00aa99 -> one cycle with icap_d=0xaa99, ce_n=0, write_n=0, icap_clk=0, then one cycle with icap_clk=1, then IDLE. busy=1 for those 2 cycles.
- IPROG burst, div=2, irq_en=1: push 0x03ffff, 0x00aa99, 0x005566, 0x0030a1, 0x000000, 0x0030a1, 0x00000e, then 4×0x002000. Required response:
  - 11 icap_clk pulses, back-to-back, each 4 cycles long, with data in push order.
  - irq rises after the 44th cycle.
  - A STATUS read clears irq.
- Overflow, fifo_depth_log2=2, div=255: push 6 words. Required response:
  - The first word is popped immediately, so 4 are stored and 1 is dropped.
  - STATUS level=4, overflow=1.
  - Writing STATUS bit1 clears overflow.
  - Exactly 5 entries are emitted.
- Push/pop collision: with the FIFO full and HOLD ending, a DATA write in the same cycle is accepted, overflow stays 0, and the level is unchanged.
- Divider change: set div=3 during an entry that started with div=1 -> the current entry keeps a 1+1 cycle timing, and the next entry uses 3+3 cycles.

Source files
------------

// File: rtl/sysctl_icap_seq.sv
`default_nettype none
// ============================================================================
// sysctl_icap_seq : CSR-fed FIFO sequencer that replays words onto an ICAP port
// Rev 1.0
// ============================================================================
module sysctl_icap_seq #(
   parameter logic [3:0] CSR_ADDR        = 4'h0,
   parameter int         DATA_WIDTH      = 16,
   parameter int         FIFO_DEPTH_LOG2 = 5,
   parameter logic [7:0] DEFAULT_DIV     = 8'd4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [13:0]           csr_a,
   input  logic                  csr_we,
   input  logic [31:0]           csr_di,
   output logic [31:0]           csr_do,
   output logic                  icap_clk,
   output logic                  icap_ce_n,
   output logic                  icap_write_n,
   output logic [DATA_WIDTH-1:0] icap_d,
   output logic                  irq
);
   localparam int                   DEPTH   = 2 ** FIFO_DEPTH_LOG2;
   localparam int                   EW      = DATA_WIDTH + 2;
   localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE = 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, HOLD = 2'd2} state_t;
   state_t state, state_nxt;

   logic [EW-1:0]            mem [DEPTH];
   logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr, level;
   logic                     full, empty, busy;
   logic                     sel, push_req, push_ok, pop;
   logic                     stat_wr, stat_rd, ctrl_wr;
   logic                     overflow, drained, irq_en;
   logic [7:0]               div, eff_div, ent_div, phase;
   logic [EW-1:0]            head;
   logic [31:0]              rd_val;
   logic                     unused_bits;

   assign sel      = (csr_a[13:10] == CSR_ADDR);
   assign push_req = sel & csr_we & (csr_a[1:0] == 2'd0);
   assign stat_wr  = sel & csr_we & (csr_a[1:0] == 2'd1);
   assign stat_rd  = sel & ~csr_we & (csr_a[1:0] == 2'd1);
   assign ctrl_wr  = sel & csr_we & (csr_a[1:0] == 2'd2);

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}});
   // a pop in the same cycle frees a slot, so a full FIFO may still accept
   assign push_ok = push_req & (~full | pop);
   assign busy    = (state != IDLE) | ~empty;
   assign eff_div = (div == 8'd0) ? 8'd1 : div;
   assign head    = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
   assign irq     = irq_en & drained;
   assign unused_bits = ^{csr_di, csr_a};

   always_ff @(posedge sys_clk) begin
      if (push_ok)
         mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {csr_di[17], csr_di[16], csr_di[DATA_WIDTH-1:0]};
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (phase == 8'd1) state_nxt = HOLD;
         end
         HOLD: begin
            if (phase == 8'd1) begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = SETUP;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state        <= IDLE;
         phase        <= 8'd0;
         ent_div      <= 8'd1;
         icap_clk     <= 1'b0;
         icap_ce_n    <= 1'b1;
         icap_write_n <= 1'b1;
         icap_d       <= '0;
      end else begin
         state    <= state_nxt;
         icap_clk <= (state_nxt == HOLD);
         // the divider is sampled only at entry start so an entry keeps its timing
         if (pop) begin
            phase   <= eff_div;
            ent_div <= eff_div;
            {icap_write_n, icap_ce_n, icap_d} <= head;
         end else if (state == SETUP && phase == 8'd1) begin
            phase <= ent_div;
         end else if (state != IDLE) begin
            phase <= phase - 8'd1;
         end
         if (!pop && state_nxt == IDLE) begin
            icap_ce_n    <= 1'b1;
            icap_write_n <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (sel) begin
         case (csr_a[1:0])
            2'd1:    rd_val = {16'd0, 8'(level), 5'd0, empty, overflow, busy};
            2'd2:    rd_val = {23'd0, irq_en, div};
            default: rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         div      <= DEFAULT_DIV;
         irq_en   <= 1'b0;
         drained  <= 1'b0;
         csr_do   <= '0;
      end else begin
         csr_do <= rd_val;
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         if (stat_wr && csr_di[1])        overflow <= 1'b0;
         else if (push_req && !push_ok)   overflow <= 1'b1;
         if (ctrl_wr) {irq_en, div} <= csr_di[8:0];
         if (state == HOLD && state_nxt == IDLE) drained <= 1'b1;
         else if (push_req || stat_rd)           drained <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sysctl_icap_seq.sv
`default_nettype none
// tb_sysctl_icap_seq : directed and randomized checks against a schedule-level
// model (queue of entries, each lasting 2*div cycles with the clock high in the second half).
module tb_sysctl_icap_seq;
   localparam logic [3:0]  CSR   = 4'h5;
   localparam int          L     = 2;
   localparam int          DEPTH = 4;
   localparam logic [13:0] OTHER = {4'h3, 10'd0};

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [13:0] csr_a   = '0;
   logic        csr_we  = 1'b0;
   logic [31:0] csr_di  = '0;
   logic [31:0] csr_do;
   logic        icap_clk, icap_ce_n, icap_write_n, irq;
   logic [15:0] icap_d;

   sysctl_icap_seq #(
      .CSR_ADDR(CSR), .DATA_WIDTH(16), .FIFO_DEPTH_LOG2(L), .DEFAULT_DIV(8'd4)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
      .csr_di(csr_di), .csr_do(csr_do), .icap_clk(icap_clk), .icap_ce_n(icap_ce_n),
      .icap_write_n(icap_write_n), .icap_d(icap_d), .irq(irq)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // model state
   logic [17:0] mq[$];
   bit          m_act, m_irqen, m_ovf, m_drn;
   int          m_e, m_d;
   logic [17:0] m_cur;
   logic [15:0] m_last;
   logic [7:0]  m_div;
   int          pulses;
   logic        prev_clk;

   logic [31:0] iprog [11] = '{32'h03ffff, 32'h00aa99, 32'h005566, 32'h0030a1, 32'h000000,
                               32'h0030a1, 32'h00000e, 32'h002000, 32'h002000, 32'h002000,
                               32'h002000};

   function automatic logic [13:0] ad(input logic [1:0] i);
      return {CSR, 8'd0, i};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_act = 0; m_e = 0; m_d = 1; m_cur = '0; m_last = '0;
      m_div = 8'd4; m_irqen = 0; m_ovf = 0; m_drn = 0;
   endtask

   // called at a negedge: drive inputs, advance model over the next posedge, compare at next negedge
   task automatic step(input logic we, input logic [13:0] a, input logic [31:0] di);
      logic sel, push, pop, ending, acc;
      logic [1:0] idx;
      logic [31:0] exp_do;
      logic exp_clk, exp_ce, exp_wn;
      logic [15:0] exp_d;
      int n;
      csr_we = we; csr_a = a; csr_di = di;
      sel = (a[13:10] == CSR);
      idx = a[1:0];
      n   = mq.size();
      exp_do = '0;
      if (sel && idx == 2'd1)
         exp_do = {16'd0, 8'(n), 5'd0, (n == 0), m_ovf, (m_act || n > 0)};
      else if (sel && idx == 2'd2)
         exp_do = {23'd0, m_irqen, m_div};
      push   = sel && we && idx == 2'd0;
      ending = m_act && (m_e == 2 * m_d - 1);
      pop    = (!m_act || ending) && n > 0;
      acc    = push && (n < DEPTH || pop);
      if (push && !acc) m_ovf = 1;
      if (sel && we && idx == 2'd1 && di[1]) m_ovf = 0;
      if (push || (sel && !we && idx == 2'd1)) m_drn = 0;
      if (ending && !pop) m_drn = 1;
      if (pop) begin
         m_cur  = mq.pop_front();
         m_act  = 1;
         m_e    = 0;
         m_d    = (m_div == 8'd0) ? 1 : int'(m_div);
         m_last = m_cur[15:0];
      end else if (ending) begin
         m_act = 0;
      end else if (m_act) begin
         m_e++;
      end
      if (acc) mq.push_back(di[17:0]);
      if (sel && we && idx == 2'd2) begin
         m_div   = di[7:0];
         m_irqen = di[8];
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_clk = m_act && (m_e >= m_d);
      exp_ce  = m_act ? m_cur[16] : 1'b1;
      exp_wn  = m_act ? m_cur[17] : 1'b1;
      exp_d   = m_act ? m_cur[15:0] : m_last;
      check("port", {icap_clk, icap_ce_n, icap_write_n, icap_d}, {exp_clk, exp_ce, exp_wn, exp_d});
      check("csr_do", csr_do, exp_do);
      check("irq", irq, m_irqen && m_drn);
      if (icap_clk && !prev_clk) pulses++;
      prev_clk = icap_clk;
   endtask

   task automatic drain();
      for (int c = 0; c < 3000 && (m_act || mq.size() > 0); c++) step(1'b0, OTHER, 32'd0);
      step(1'b0, OTHER, 32'd0);
   endtask

   initial begin
      int k, r;
      model_reset();
      pulses = 0; prev_clk = 1'b0;
      repeat (2) @(negedge sys_clk);
      check("rst_port", {icap_clk, icap_ce_n, icap_write_n, icap_d, irq, csr_do},
            {1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 32'd0});
      sys_rst = 1'b0;
      step(1'b0, ad(2'd1), 32'd0);
      check("rst_status", csr_do, 32'h4);
      step(1'b0, ad(2'd2), 32'd0);
      check("rst_ctrl", csr_do, 32'h4);

      // single entry at div=1
      step(1'b1, ad(2'd2), 32'h1);
      step(1'b1, ad(2'd0), 32'h00aa99);
      step(1'b0, ad(2'd1), 32'd0);
      check("single_d", {icap_clk, icap_ce_n, icap_write_n, icap_d}, {3'b000, 16'haa99});
      step(1'b0, ad(2'd1), 32'd0);
      check("single_hi", icap_clk, 1'b1);
      step(1'b0, ad(2'd1), 32'd0);
      step(1'b0, ad(2'd1), 32'd0);
      check("single_idle", csr_do[0], 1'b0);

      // IPROG burst, div=2, irq enabled
      step(1'b1, ad(2'd2), 32'h102);
      pulses = 0; k = 0;
      for (int c = 0; c < 200 && (k < 11 || m_act || mq.size() > 0); c++) begin
         if (k < 11 && mq.size() < DEPTH) begin
            step(1'b1, ad(2'd0), iprog[k]);
            k++;
         end else begin
            step(1'b0, OTHER, 32'd0);
         end
      end
      check("iprog_pulses", pulses, 11);
      check("iprog_irq", irq, 1'b1);
      step(1'b0, ad(2'd1), 32'd0);
      check("irq_clear", irq, 1'b0);

      // overflow at div=255
      step(1'b1, ad(2'd2), 32'hff);
      pulses = 0;
      for (int i = 0; i < 6; i++) step(1'b1, ad(2'd0), 32'h30000 | (i * 32'h1111));
      step(1'b0, ad(2'd1), 32'd0);
      check("ovf_level", csr_do[15:8], 8'd4);
      check("ovf_flag", csr_do[1], 1'b1);
      step(1'b1, ad(2'd1), 32'h2);
      step(1'b0, ad(2'd1), 32'd0);
      check("ovf_clear", csr_do[1], 1'b0);
      drain();
      check("ovf_emitted", pulses, 5);

      // push/pop collision with a full FIFO
      step(1'b1, ad(2'd2), 32'h2);
      for (int i = 0; i < 5; i++) step(1'b1, ad(2'd0), 32'h0c000 + i);
      for (int c = 0; c < 20 && !(m_act && m_e == 2 * m_d - 1); c++) step(1'b0, OTHER, 32'd0);
      step(1'b1, ad(2'd0), 32'h0beef);
      step(1'b0, ad(2'd1), 32'd0);
      check("coll_level", csr_do[15:8], 8'd4);
      check("coll_ovf", csr_do[1], 1'b0);
      drain();

      // divider change mid-entry
      step(1'b1, ad(2'd2), 32'h1);
      pulses = 0;
      step(1'b1, ad(2'd0), 32'h01234);
      step(1'b0, OTHER, 32'd0);
      step(1'b1, ad(2'd2), 32'h3);
      step(1'b1, ad(2'd0), 32'h05678);
      drain();
      check("div_pulses", pulses, 2);

      // reset asserted during HOLD
      step(1'b1, ad(2'd2), 32'h4);
      step(1'b1, ad(2'd0), 32'h0abcd);
      for (int c = 0; c < 20 && !(m_act && m_e >= m_d); c++) step(1'b0, OTHER, 32'd0);
      check("hold_before_rst", icap_clk, 1'b1);
      #2 sys_rst = 1'b1;
      #1 check("async_rst", {icap_clk, icap_ce_n, icap_write_n}, 3'b011);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      prev_clk = 1'b0;
      step(1'b0, ad(2'd1), 32'd0);
      check("post_rst_status", csr_do, 32'h4);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 99);
         if (r < 35)      step(1'b1, ad(2'd0), $urandom & 32'h3ffff);
         else if (r < 42) step(1'b1, ad(2'd2), {23'd0, 1'($urandom), 8'($urandom_range(0, 3))});
         else if (r < 50) step(1'b1, ad(2'd1), $urandom);
         else if (r < 65) step(1'b0, ad(2'd1), 32'd0);
         else if (r < 72) step(1'b0, ad(2'd2), 32'd0);
         else if (r < 77) step(1'($urandom), ad(2'd3), $urandom);
         else if (r < 82) step(1'b1, 14'($urandom), $urandom);
         else             step(1'b0, OTHER, 32'd0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
